// File: rtl/random_y_fifo_gen_if.sv
// Request/valid handshake and status bundle between the Y generator and the pipe spawner.
interface random_y_fifo_gen_if #(
    parameter int unsigned WIDTH = 7
);
    logic             user_input;
    logic             next_req;
    logic [WIDTH-1:0] random_number;
    logic             valid;
    logic             empty;
    logic             full;
    logic             overflow;

    modport master (
        output user_input, next_req,
        input  random_number, valid, empty, full, overflow
    );

    modport slave (
        input  user_input, next_req,
        output random_number, valid, empty, full, overflow
    );
endinterface

// File: rtl/random_y_fifo_gen.sv
// Pipe-opening Y generator: wrap-around down-counter sampled on button edges into a small FIFO.
// Optional LFSR mixing of the sample is enabled by defining RANDOM_LFSR_MIX_EN.
module random_y_fifo_gen #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned Y_MIN = 30,
    parameter int unsigned Y_MAX = 100,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    random_y_fifo_gen_if.slave bus
);
    localparam int unsigned RANGE = Y_MAX - Y_MIN + 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = AW + 1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             user_input_q, user_input_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] random_number_q, random_number_d;
    logic             valid_q, valid_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] sample;
    logic             rise;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;

`ifdef RANDOM_LFSR_MIX_EN
    localparam int unsigned TW = WIDTH + 1;

    if (RANGE < (2 ** (WIDTH - 1))) begin : g_range_check
        $error("random_y_fifo_gen: Y_MAX - Y_MIN + 1 must be >= 2**(WIDTH-1) for LFSR mixing");
    end

    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] off;
    logic [TW-1:0]    t;

    // Fibonacci LFSR, taps 16,14,13,11; offset folded back into [Y_MIN, Y_MAX].
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        off    = {1'b0, lfsr_q[WIDTH-2:0]};
        t      = TW'(count_q) - TW'(Y_MIN) + TW'(off);
        sample = WIDTH'(Y_MIN) + WIDTH'((t >= TW'(RANGE)) ? (t - TW'(RANGE)) : t);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    always_comb begin
        sample = count_q;
    end
`endif

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    end

    // Counter, edge capture, FIFO pointers and request delivery.
    always_comb begin
        count_d         = (count_q <= WIDTH'(Y_MIN)) ? WIDTH'(Y_MAX) : (count_q - WIDTH'(1));
        user_input_d    = bus.user_input;
        rise            = bus.user_input & ~user_input_q;
        pop             = bus.next_req & ~fifo_empty;
        // A full FIFO still accepts the capture when a pop frees a slot in the same cycle.
        push            = rise & (~fifo_full | pop);
        overflow_d      = overflow_q | (rise & fifo_full & ~pop);
        wr_ptr_d        = wr_ptr_q + PW'(push);
        rd_ptr_d        = rd_ptr_q + PW'(pop);
        empty_d         = (wr_ptr_d == rd_ptr_d);
        full_d          = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                          (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
        valid_d         = bus.next_req;
        random_number_d = random_number_q;
        if (bus.next_req) begin
            random_number_d = fifo_empty ? sample : mem_q[rd_ptr_q[PW-2:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q         <= WIDTH'(Y_MAX);
            user_input_q    <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            random_number_q <= WIDTH'(Y_MAX);
            valid_q         <= 1'b0;
            empty_q         <= 1'b1;
            full_q          <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            count_q         <= count_d;
            user_input_q    <= user_input_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            random_number_q <= random_number_d;
            valid_q         <= valid_d;
            empty_q         <= empty_d;
            full_q          <= full_d;
            overflow_q      <= overflow_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= sample;
        end
    end

    assign bus.random_number = random_number_q;
    assign bus.valid         = valid_q;
    assign bus.empty         = empty_q;
    assign bus.full          = full_q;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_random_y_fifo_gen.sv
// Randomised self-checking bench for random_y_fifo_gen against a queue-based reference model.
module tb_random_y_fifo_gen;
    localparam int unsigned WIDTH = 7;
    localparam int unsigned Y_MIN = 30;
    localparam int unsigned Y_MAX = 100;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RANGE = Y_MAX - Y_MIN + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    random_y_fifo_gen_if #(.WIDTH(WIDTH)) bus ();

    random_y_fifo_gen #(
        .WIDTH(WIDTH), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned q[$];
    int unsigned edge_idx;
    int unsigned exp_rn;
    bit          exp_valid;
    bit          exp_ovf;
    bit          ui_prev;
`ifdef RANDOM_LFSR_MIX_EN
    logic [15:0] lfsr_m;
`endif

    function automatic int unsigned model_sample();
        int unsigned cnt;
        cnt = Y_MAX - (edge_idx % RANGE);
`ifdef RANDOM_LFSR_MIX_EN
        begin
            int unsigned off;
            int unsigned t;
            off = int'(lfsr_m) % (1 << (WIDTH - 1));
            t   = (cnt - Y_MIN) + off;
            return Y_MIN + (t % RANGE);
        end
`else
        return cnt;
`endif
    endfunction

    function automatic void model_init();
        q.delete();
        edge_idx  = 0;
        exp_rn    = Y_MAX;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        ui_prev   = 1'b0;
`ifdef RANDOM_LFSR_MIX_EN
        lfsr_m = 16'hACE1;
`endif
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1ns after it.
    task automatic step(input logic ui, input logic req);
        int unsigned s;
        bit rise, pop, was_full;
        bus.user_input = ui;
        bus.next_req   = req;
        @(posedge clk);
        s        = model_sample();
        rise     = ui && !ui_prev;
        ui_prev  = ui;
        was_full = (q.size() == DEPTH);
        pop      = req && (q.size() != 0);
        exp_valid = req;
        if (req) exp_rn = pop ? q.pop_front() : s;
        if (rise) begin
            if (!was_full || pop) q.push_back(s);
            else exp_ovf = 1'b1;
        end
        edge_idx++;
`ifdef RANDOM_LFSR_MIX_EN
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`endif
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.user_input = 1'b0;
        bus.next_req   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    task automatic advance_to(input int unsigned e);
        while (edge_idx < e) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.random_number !== WIDTH'(Y_MAX)) begin errors++; $display("FAIL reset_rn got %0d exp %0d", bus.random_number, Y_MAX); end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        advance_to(70);
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL wrap_min got %0d/%b exp %0d/1", bus.random_number, bus.valid, exp_rn); end
`ifndef RANDOM_LFSR_MIX_EN
        checks++; if (bus.random_number !== WIDTH'(Y_MIN)) begin errors++; $display("FAIL wrap_min_const got %0d exp %0d", bus.random_number, Y_MIN); end
`endif
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL wrap_reload got %0d/%b exp %0d/1", bus.random_number, bus.valid, exp_rn); end
`ifndef RANDOM_LFSR_MIX_EN
        checks++; if (bus.random_number !== WIDTH'(Y_MAX)) begin errors++; $display("FAIL wrap_reload_const got %0d exp %0d", bus.random_number, Y_MAX); end
`endif
        step(1'b0, 1'b0);
        checks++; if (bus.valid !== 1'b0 || bus.random_number !== WIDTH'(exp_rn)) begin errors++; $display("FAIL wrap_hold got %0d/%b exp %0d/0", bus.random_number, bus.valid, exp_rn); end
    endtask

    task automatic test_held_button();
        do_reset();
        advance_to(13);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        checks++; if (bus.empty !== 1'b0 || q.size() != 1) begin errors++; $display("FAIL held_one_push empty got %b exp 0 (model depth %0d)", bus.empty, q.size()); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL held_value got %0d/%b exp %0d/1", bus.random_number, bus.valid, exp_rn); end
`ifndef RANDOM_LFSR_MIX_EN
        checks++; if (bus.random_number !== WIDTH'(87)) begin errors++; $display("FAIL held_value_const got %0d exp 87", bus.random_number); end
`endif
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL held_empty_after got %b exp 1", bus.empty); end
    endtask

    task automatic test_empty_request();
        do_reset();
        advance_to(45);
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL empty_req got %0d/%b exp %0d/1", bus.random_number, bus.valid, exp_rn); end
`ifndef RANDOM_LFSR_MIX_EN
        checks++; if (bus.random_number !== WIDTH'(55)) begin errors++; $display("FAIL empty_req_const got %0d exp 55", bus.random_number); end
`endif
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL empty_req_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        while (edge_idx <= 50) begin
            step((edge_idx >= 10) && (edge_idx % 10 == 0), 1'b0);
            if (edge_idx == 41) begin
                checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_full4 got full %b ovf %b exp 1/0", bus.full, bus.overflow); end
            end
        end
        checks++; if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin errors++; $display("FAIL ovf_drop got ovf %b full %b exp 1/1", bus.overflow, bus.full); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL ovf_pop%0d got %0d/%b exp %0d/1", i, bus.random_number, bus.valid, exp_rn); end
`ifndef RANDOM_LFSR_MIX_EN
            checks++; if (bus.random_number !== WIDTH'(90 - 10 * i)) begin errors++; $display("FAIL ovf_pop%0d_const got %0d exp %0d", i, bus.random_number, 90 - 10 * i); end
`endif
        end
        step(1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b1 || bus.valid !== 1'b0) begin errors++; $display("FAIL ovf_after got empty %b ovf %b valid %b exp 1/1/0", bus.empty, bus.overflow, bus.valid); end
    endtask

    // Overflow is still set from the previous scenario, so reset must visibly clear it.
    task automatic test_reset_mid();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL rstmid_pre_empty got %b exp 0", bus.empty); end
        bus.next_req = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL rstmid_flags got empty %b full %b exp 1/0", bus.empty, bus.full); end
        checks++; if (bus.valid !== 1'b0 || bus.random_number !== WIDTH'(Y_MAX)) begin errors++; $display("FAIL rstmid_out got %0d/%b exp %0d/0", bus.random_number, bus.valid, Y_MAX); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", bus.overflow); end
        do_reset();
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid_after got %0d empty %b exp %0d/1", bus.random_number, bus.empty, exp_rn); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", bus.full); end
        step(1'b1, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== 1'b1) begin errors++; $display("FAIL fpp_head got %0d/%b exp %0d/1", bus.random_number, bus.valid, exp_rn); end
        checks++; if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_flags got full %b ovf %b exp 1/0", bus.full, bus.overflow); end
        step(1'b0, 1'b1);
        checks++; if (bus.random_number !== WIDTH'(exp_rn)) begin errors++; $display("FAIL fpp_next got %0d exp %0d", bus.random_number, exp_rn); end
    endtask

    task automatic test_random();
        logic ui, req;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ui  = ($urandom_range(0, 2) == 0) ? ~ui_prev : ui_prev;
            req = ($urandom_range(0, 3) == 0);
            step(ui, req);
            checks++; if (bus.random_number !== WIDTH'(exp_rn) || bus.valid !== exp_valid) begin errors++; $display("FAIL rand_out step %0d got %0d/%b exp %0d/%b", i, bus.random_number, bus.valid, exp_rn, exp_valid); end
            checks++; if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) || bus.overflow !== exp_ovf) begin errors++; $display("FAIL rand_flags step %0d got e%b f%b o%b exp depth %0d o%b", i, bus.empty, bus.full, bus.overflow, q.size(), exp_ovf); end
            checks++; if (int'(bus.random_number) < int'(Y_MIN) || int'(bus.random_number) > int'(Y_MAX)) begin errors++; $display("FAIL rand_range step %0d got %0d", i, bus.random_number); end
            if (i % 1000 == 999) do_reset();
        end
    endtask

    initial begin
        bus.user_input = 1'b0;
        bus.next_req   = 1'b0;
        model_init();
        test_reset();
        test_counter_wrap();
        test_held_button();
        test_empty_request();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
